// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target
// Contents:
//   state_t  target protocol state
//   ACK_BIT  bit counter value of the ninth (acknowledge) clock slot
//   BYTE_W   data byte width
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic [3:0] ACK_BIT = 4'd8;
  localparam int         BYTE_W  = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - N-stage input synchronizer with rise/fall detection
// Ports:
//   clk, rst  fabric clock, asynchronous active-high reset
//   din       asynchronous bus level
//   level     synchronized level (resets to 1, idle bus)
//   rise      one-cycle strobe on synchronized 0->1
//   fall      one-cycle strobe on synchronized 1->0
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target: START/STOP detect, 7-bit address match, write/read byte streams
// Build option: I2C_TGT_STRETCH_EN holds SCL low in RD_LOAD until rd_valid
// Ports:
//   CLK, RST                    fabric clock, asynchronous active-high reset
//   scl_i, sda_i                bus levels from the IOBUF outputs
//   sda_t, scl_t                IOBUF tristate controls, 1 = release, 0 = pull low
//   wr_data, wr_valid           received write byte and its one-cycle strobe
//   rd_data, rd_valid, rd_ready byte to transmit, consumed on the rd_ready pulse
//   busy                        addressed, transfer in progress
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_t,
  output logic              scl_t,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic [BYTE_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic              busy
);

  localparam logic [3:0] LAST_BIT = 4'd7;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (CLK),
    .rst   (RST),
    .din   (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (CLK),
    .rst   (RST),
    .din   (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL must already have been high for an SDA edge to count as START/STOP.
  // When a stretch release and the first data bit land in the same cycle,
  // the SDA change is then treated as data, not as a bus condition.
  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl & ~scl_rise;
  assign stop_ev  = sda_rise & scl_lvl & ~scl_rise;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              rw_bit;

  logic [BYTE_W-1:0] rx_byte;
  logic [3:0]        cnt_next;
  assign rx_byte  = {shreg[BYTE_W-2:0], sda_lvl};
  assign cnt_next = (bit_cnt == ACK_BIT) ? 4'd0 : bit_cnt + 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= '0;
      rw_bit   <= 1'b0;
      sda_t    <= 1'b1;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      rd_ready <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
      scl_t    <= 1'b1;
`endif
    end else begin
      wr_valid <= 1'b0;
      rd_ready <= 1'b0;
      if (start_ev) begin
        // Repeated START keeps busy; a fresh address phase decides again.
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
`ifdef I2C_TGT_STRETCH_EN
        scl_t   <= 1'b1;
`endif
      end else if (stop_ev) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
        scl_t   <= 1'b1;
`endif
      end else begin
        if (scl_rise) bit_cnt <= cnt_next;
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt == LAST_BIT) begin
                if (shreg[6:0] == TGT_ADDR) begin
                  state  <= ADDR_ACK;
                  busy   <= 1'b1;
                  rw_bit <= sda_lvl;
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            // Counter is 8 at the 8th fall (start of slot), 0 at the 9th fall.
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sda_t <= 1'b0;
              end else begin
                sda_t <= 1'b1;
                state <= (state == ADDR_ACK && rw_bit) ? RD_LOAD : WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt == LAST_BIT) begin
                wr_data  <= rx_byte;
                wr_valid <= 1'b1;
                state    <= WR_ACK;
              end
            end
          end
          RD_LOAD: begin
            if (rd_valid) begin
              shreg    <= rd_data;
              sda_t    <= rd_data[BYTE_W-1];
              rd_ready <= 1'b1;
              state    <= RD_DATA;
`ifdef I2C_TGT_STRETCH_EN
              scl_t    <= 1'b1;
`endif
            end else begin
`ifdef I2C_TGT_STRETCH_EN
              scl_t <= 1'b0;
`else
              shreg <= '1;
              sda_t <= 1'b1;
              state <= RD_DATA;
`endif
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sda_t <= 1'b1;
                state <= RD_ACK;
              end else begin
                sda_t <= shreg[BYTE_W-2];
                shreg <= {shreg[BYTE_W-2:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_lvl) begin
              state <= IGNORE;
              busy  <= 1'b0;
            end else if (scl_fall) begin
              state <= RD_LOAD;
            end
          end
          default: begin
            sda_t <= 1'b1;
          end
        endcase
      end
    end
  end

`ifndef I2C_TGT_STRETCH_EN
  assign scl_t = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target with a bit-level bus controller
module tb_i2c_target;

  localparam int         Q    = 6;
  localparam int         H    = 12;
  localparam logic [6:0] ADDR = 7'h50;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_bus, sda_bus;
  logic       sda_t, scl_t;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data = 8'h00;
  logic       rd_valid = 1'b0;
  logic       rd_ready;
  logic       busy;

  assign scl_bus = scl_drv & scl_t;
  assign sda_bus = sda_drv & sda_t;

  i2c_target #(.TGT_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .scl_i    (scl_bus),
    .sda_i    (sda_bus),
    .sda_t    (sda_t),
    .scl_t    (scl_t),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy)
  );

  always #3 CLK = ~CLK;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] wr_q[$];
  int         rd_cnt = 0;
  int         both_cnt = 0;
  int         low_cnt = 0;
  int         stretch_cnt = 0;
  int         busy_gap = 0;
  logic       watch_busy = 1'b0;

  always @(negedge CLK) begin
    if (wr_valid === 1'b1) wr_q.push_back(wr_data);
    if (rd_ready === 1'b1) rd_cnt++;
    if (wr_valid === 1'b1 && rd_ready === 1'b1) both_cnt++;
    if (sda_t === 1'b0) low_cnt++;
    if (scl_t === 1'b0) stretch_cnt++;
    if (watch_busy && busy !== 1'b1) busy_gap++;
  end

  // Reference model: target ACKs (drives 0) only its own address; a read
  // returns the supplied byte, or all-ones when nothing was offered and the
  // target cannot stretch.
  function automatic logic exp_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == ADDR) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [7:0] exp_read(input logic valid, input logic [7:0] data);
    logic [7:0] r;
    r = valid ? data : 8'hFF;
`ifdef I2C_TGT_STRETCH_EN
    r = data;
`endif
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_cnt = 0;
    low_cnt = 0;
    stretch_cnt = 0;
    busy_gap = 0;
  endtask

  task automatic scl_up();
    int t;
    t = 0;
    scl_drv = 1'b1;
    tick(1);
    while (scl_bus !== 1'b1 && t < 5000) begin
      tick(1);
      t++;
    end
    n_tests++; if (scl_bus !== 1'b1) begin n_fail++; $display("FAIL scl_release actual=%b required=1", scl_bus); end
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;
    tick(Q);
    scl_up();
    tick(H);
    scl_drv = 1'b0;
    tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1;
    tick(Q);
    scl_up();
    tick(H / 2);
    b = sda_bus;
    tick(H / 2);
    scl_drv = 1'b0;
    tick(Q);
  endtask

  task automatic start_cond();
    sda_drv = 1'b1;
    tick(Q);
    scl_up();
    tick(H);
    sda_drv = 1'b0;
    tick(H);
    scl_drv = 1'b0;
    tick(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0;
    tick(Q);
    scl_up();
    tick(H);
    sda_drv = 1'b1;
    tick(H);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(4);
    n_tests++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL reset_sda_t actual=%b required=1", sda_t); end
    n_tests++; if (scl_t !== 1'b1) begin n_fail++; $display("FAIL reset_scl_t actual=%b required=1", scl_t); end
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid actual=%b required=0", wr_valid); end
    n_tests++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready actual=%b required=0", rd_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data actual=%h required=00", wr_data); end
    RST = 1'b0;
    tick(4);
  endtask

  task automatic test_write();
    logic       ack;
    logic [7:0] data[$];
    int         n;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      data.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) data.push_back(8'($urandom_range(0, 255)));
      if (it == 0) data[0] = 8'h3C;
      start_cond();
      write_byte({ADDR, 1'b0}, ack);
      n_tests++; if (ack !== exp_ack({ADDR, 1'b0})) begin n_fail++; $display("FAIL wr_addr_ack actual=%b required=%b", ack, exp_ack({ADDR, 1'b0})); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_set actual=%b required=1", busy); end
      for (int k = 0; k < n; k++) begin
        write_byte(data[k], ack);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack byte=%0d actual=%b required=0", k, ack); end
      end
      stop_cond();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop actual=%b required=0", busy); end
      n_tests++; if (wr_q.size() != n) begin n_fail++; $display("FAIL wr_count actual=%0d required=%0d", wr_q.size(), n); end
      for (int k = 0; k < n && k < wr_q.size(); k++) begin
        n_tests++; if (wr_q[k] !== data[k]) begin n_fail++; $display("FAIL wr_byte idx=%0d actual=%h required=%h", k, wr_q[k], data[k]); end
      end
    end
  endtask

  task automatic test_wrong_addr();
    logic       ack;
    logic [6:0] a;
    logic [7:0] d;
    for (int it = 0; it < 3; it++) begin
      clear_mon();
      a = 7'h51;
      if (it != 0) begin
        do a = 7'($urandom_range(0, 127)); while (a == ADDR);
      end
      d = 8'($urandom_range(0, 255));
      if (it == 0) d = 8'h11;
      start_cond();
      write_byte({a, 1'b0}, ack);
      n_tests++; if (ack !== exp_ack({a, 1'b0})) begin n_fail++; $display("FAIL nm_addr_ack addr=%h actual=%b required=%b", a, ack, exp_ack({a, 1'b0})); end
      write_byte(d, ack);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nm_data_ack actual=%b required=1", ack); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nm_busy actual=%b required=0", busy); end
      stop_cond();
      n_tests++; if (low_cnt != 0) begin n_fail++; $display("FAIL nm_sda_driven cycles=%0d required=0", low_cnt); end
      n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL nm_wr_valid count=%0d required=0", wr_q.size()); end
    end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] vals[$];
    logic [7:0] got;
    int         n;
    for (int it = 0; it < 3; it++) begin
      clear_mon();
      vals.delete();
      n = (it == 0) ? 1 : $urandom_range(2, 3);
      for (int k = 0; k < n; k++) vals.push_back(8'($urandom_range(0, 255)));
      if (it == 0) vals[0] = 8'h5A;
      rd_data = vals[0];
      rd_valid = 1'b1;
      start_cond();
      write_byte({ADDR, 1'b1}, ack);
      n_tests++; if (ack !== exp_ack({ADDR, 1'b1})) begin n_fail++; $display("FAIL rd_addr_ack actual=%b required=%b", ack, exp_ack({ADDR, 1'b1})); end
      for (int k = 0; k < n; k++) begin
        recv_byte(got);
        n_tests++; if (got !== exp_read(1'b1, vals[k])) begin n_fail++; $display("FAIL rd_byte idx=%0d actual=%h required=%h", k, got, exp_read(1'b1, vals[k])); end
        if (k < n - 1) rd_data = vals[k+1];
        send_bit(k == n - 1);
      end
      n_tests++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL rd_release_after_nack actual=%b required=1", sda_t); end
      n_tests++; if (rd_cnt != n) begin n_fail++; $display("FAIL rd_ready_count actual=%0d required=%0d", rd_cnt, n); end
      stop_cond();
      rd_valid = 1'b0;
    end
  endtask

  task automatic test_read_empty();
    logic       ack;
    logic [7:0] got;
    int         exp_cnt;
    clear_mon();
    rd_valid = 1'b0;
    rd_data = 8'h5A;
    exp_cnt = 0;
    start_cond();
    write_byte({ADDR, 1'b1}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL empty_addr_ack actual=%b required=0", ack); end
`ifdef I2C_TGT_STRETCH_EN
    begin
      int held;
      held = 0;
      for (int i = 0; i < 200; i++) begin
        tick(1);
        if (scl_t === 1'b0) held++;
      end
      n_tests++; if (held != 200) begin n_fail++; $display("FAIL stretch_hold cycles=%0d required=200", held); end
      rd_valid = 1'b1;
      exp_cnt = 1;
    end
`else
    tick(20);
`endif
    recv_byte(got);
    send_bit(1'b1);
    n_tests++; if (got !== exp_read(1'b0, 8'h5A)) begin n_fail++; $display("FAIL empty_byte actual=%h required=%h", got, exp_read(1'b0, 8'h5A)); end
    n_tests++; if (rd_cnt != exp_cnt) begin n_fail++; $display("FAIL empty_rd_ready actual=%0d required=%0d", rd_cnt, exp_cnt); end
`ifndef I2C_TGT_STRETCH_EN
    n_tests++; if (stretch_cnt != 0) begin n_fail++; $display("FAIL empty_scl_stretched cycles=%0d required=0", stretch_cnt); end
`endif
    stop_cond();
    rd_valid = 1'b0;
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] r;
    logic [7:0] got;
    clear_mon();
    r = 8'($urandom_range(0, 255));
    rd_data = r;
    rd_valid = 1'b1;
    start_cond();
    write_byte({ADDR, 1'b0}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_w_ack actual=%b required=0", ack); end
    watch_busy = 1'b1;
    write_byte(8'h01, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_data_ack actual=%b required=0", ack); end
    start_cond();
    write_byte({ADDR, 1'b1}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_r_ack actual=%b required=0", ack); end
    recv_byte(got);
    watch_busy = 1'b0;
    send_bit(1'b1);
    stop_cond();
    rd_valid = 1'b0;
    n_tests++; if (got !== exp_read(1'b1, r)) begin n_fail++; $display("FAIL rs_read_byte actual=%h required=%h", got, r); end
    n_tests++; if (busy_gap != 0) begin n_fail++; $display("FAIL rs_busy_dropped cycles=%0d required=0", busy_gap); end
    n_tests++; if (wr_q.size() != 1 || wr_q[0] !== 8'h01) begin n_fail++; $display("FAIL rs_wr_byte count=%0d required=1 (byte 01)", wr_q.size()); end
    n_tests++; if (rd_cnt != 1) begin n_fail++; $display("FAIL rs_rd_ready actual=%0d required=1", rd_cnt); end
  endtask

  task automatic test_reset_mid_read();
    logic       ack;
    logic       b;
    logic [3:0] nib;
    logic [7:0] r;
    logic [7:0] d;
    clear_mon();
    r = 8'($urandom_range(0, 255)) & 8'hE7;
    rd_data = r;
    rd_valid = 1'b1;
    start_cond();
    write_byte({ADDR, 1'b1}, ack);
    nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      recv_bit(b);
      nib = {nib[2:0], b};
    end
    n_tests++; if (nib !== r[7:4]) begin n_fail++; $display("FAIL mr_first_bits actual=%h required=%h", nib, r[7:4]); end
    sda_drv = 1'b1;
    tick(Q);
    scl_up();
    tick(2);
    n_tests++; if (sda_t !== 1'b0) begin n_fail++; $display("FAIL mr_bit4_driven actual=%b required=0", sda_t); end
    #1;
    RST = 1'b1;
    #1;
    n_tests++; if (sda_t !== 1'b1) begin n_fail++; $display("FAIL mr_async_release actual=%b required=1", sda_t); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy_cleared actual=%b required=0", busy); end
    rd_valid = 1'b0;
    tick(3);
    RST = 1'b0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    tick(H);
    clear_mon();
    d = 8'($urandom_range(0, 255));
    start_cond();
    write_byte({ADDR, 1'b0}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mr_readdress_ack actual=%b required=0", ack); end
    write_byte(d, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mr_data_ack actual=%b required=0", ack); end
    stop_cond();
    n_tests++; if (wr_q.size() != 1 || wr_q[0] !== d) begin n_fail++; $display("FAIL mr_wr_byte count=%0d required=1 (byte %h)", wr_q.size(), d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_read_empty();
    test_repeated_start();
    test_reset_mid_read();
    n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL wr_rd_overlap cycles=%0d required=0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
